// File: rtl/vxc_pkg.sv
// Shared definitions for the vxc row sequencer: default sizes, FSM state
// encoding and helpers for chunk count and last-chunk lane masking.
package vxc_pkg;

  localparam int VXC_EW     = 32;
  localparam int VXC_NI     = 8;
  localparam int VXC_NOE    = 16;
  localparam int VXC_MAX_NI = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } vxc_state_e;

  function automatic int chunk_count(input int noe, input int ni);
    return (noe + ni - 1) / ni;
  endfunction

  // Lanes that carry real elements in the final chunk; all lanes when NI divides NOE.
  function automatic logic [VXC_MAX_NI-1:0] last_lane_mask(input int noe, input int ni);
    int lanes;
    lanes = noe % ni;
    if (lanes == 0) lanes = ni;
    last_lane_mask = '0;
    for (int j = 0; j < VXC_MAX_NI; j++) begin
      if (j < lanes) last_lane_mask[j] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/vxc_inflight_tracker.sv
// Valid/index delay line that follows each issued chunk through memory read
// and datapath latency; clear drops everything in flight.
module vxc_inflight_tracker #(
  parameter int DEPTH = 5,
  parameter int IW    = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_vld,
  input  logic [IW-1:0]    in_idx,
  output logic [DEPTH-1:0] vld,
  output logic [IW-1:0]    head_idx,
  output logic [IW-1:0]    tail_idx
);

  logic [DEPTH-1:0] vld_p;
  logic [IW-1:0]    idx_p [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) vld_p <= '0;
    else       vld_p <= {vld_p[DEPTH-2:0], in_vld};
  end

  always_ff @(posedge clk) begin
    idx_p[0] <= in_idx;
    for (int i = 1; i < DEPTH; i++) idx_p[i] <= idx_p[i-1];
  end

  assign vld      = vld_p;
  assign head_idx = idx_p[0];
  assign tail_idx = idx_p[DEPTH-1];

endmodule

// File: rtl/vxc_row_sequencer.sv
// Streams one vector pair chunk-by-chunk into the vxc datapath and writes results back.
// Optional VXC_SEQ_CYCLE_COUNT_EN adds a run_cycles busy-cycle counter output.
module vxc_row_sequencer
  import vxc_pkg::*;
#(
  parameter int NOE = VXC_NOE,
  parameter int NI  = VXC_NI,
  parameter int EW  = VXC_EW,
  parameter int LAT = 4,
  parameter int AW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_in,
  input  logic [EW-1:0]    constant_in,
  input  logic [AW-1:0]    base_addr,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    a_rd_addr,
  output logic [AW-1:0]    b_rd_addr,
  input  logic [EW*NI-1:0] a_rd_data,
  input  logic [EW*NI-1:0] b_rd_data,
  output logic [EW*NI-1:0] dp_first,
  output logic [EW*NI-1:0] dp_second,
  output logic [EW-1:0]    dp_constant,
  output logic             dp_op,
  input  logic [EW*NI-1:0] dp_result,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [NI-1:0]    wr_mask
`ifdef VXC_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]      run_cycles
`endif
);

  localparam int                    CHUNKS        = chunk_count(NOE, NI);
  localparam int                    DEPTH         = LAT + 1;
  localparam logic [VXC_MAX_NI-1:0] LAST_MASK_ALL = last_lane_mask(NOE, NI);
  localparam logic [NI-1:0]         LAST_MASK     = LAST_MASK_ALL[NI-1:0];
  localparam logic [AW-1:0]         LAST_K        = AW'(CHUNKS - 1);

  vxc_state_e       state, state_nx;
  logic [AW-1:0]    chunk_k, base_q;
  logic             op_q;
  logic [EW-1:0]    const_q;
  logic             issue, accept;
  logic [DEPTH-1:0] trk_vld;
  logic [AW-1:0]    head_idx, tail_idx;
  logic [NI-1:0]    head_lanes;
  logic             unused_dp_result;

  assign issue  = (state == ISSUE);
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: if (chunk_k == LAST_K) state_nx = DRAIN;
      // Only the tail may still be valid: it writes this cycle and leaves the tracker empty.
      DRAIN: if (~|trk_vld[DEPTH-2:0]) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chunk_k <= '0;
      base_q  <= '0;
      op_q    <= 1'b0;
      const_q <= '0;
    end else if (accept) begin
      chunk_k <= '0;
      base_q  <= base_addr;
      op_q    <= op_in;
      const_q <= constant_in;
    end else if (issue) begin
      chunk_k <= chunk_k + 1'b1;
    end
  end

  vxc_inflight_tracker #(
    .DEPTH (DEPTH),
    .IW    (AW)
  ) u_tracker (
    .clk      (clk),
    .clear    (reset),
    .in_vld   (issue),
    .in_idx   (chunk_k),
    .vld      (trk_vld),
    .head_idx (head_idx),
    .tail_idx (tail_idx)
  );

  assign a_rd_addr = issue ? base_q + chunk_k : '0;
  assign b_rd_addr = issue ? base_q + chunk_k : '0;

  // Operand stage: read data of the head chunk, padding lanes zeroed.
  assign head_lanes = trk_vld[0] ? ((head_idx == LAST_K) ? LAST_MASK : '1) : '0;

  always_comb begin
    dp_first  = '0;
    dp_second = '0;
    for (int j = 0; j < NI; j++) begin
      if (head_lanes[j]) begin
        dp_first[EW*(NI-j)-1 -: EW]  = a_rd_data[EW*(NI-j)-1 -: EW];
        dp_second[EW*(NI-j)-1 -: EW] = b_rd_data[EW*(NI-j)-1 -: EW];
      end
    end
  end

  assign dp_op       = op_q;
  assign dp_constant = const_q;

  // Write stage: tail of the tracker lines up with dp_result.
  assign wr_en   = trk_vld[DEPTH-1];
  assign wr_addr = wr_en ? base_q + tail_idx : '0;
  assign wr_mask = wr_en ? ((tail_idx == LAST_K) ? LAST_MASK : '1) : '0;

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);

  // Result data goes straight from the datapath to the result memory.
  assign unused_dp_result = ^dp_result;

`ifdef VXC_SEQ_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)       run_cycles <= '0;
    else if (accept) run_cycles <= '0;
    else if (busy)   run_cycles <= run_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vxc_row_sequencer.sv
// Scoreboard bench for vxc_row_sequencer: two instances (NOE=16 and NOE=12)
// with memory and datapath models, checked against a per-run reference.
module tb_vxc_row_sequencer;

  localparam int NI  = 8;
  localparam int EW  = 32;
  localparam int LAT = 4;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          op_in = 1'b0;
  logic [EW-1:0] constant_in = '0;
  logic [AW-1:0] base_addr = '0;
  bit            chk_three = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW*NI-1:0] mem_a [256];
  logic [EW*NI-1:0] mem_b [256];

  typedef struct {
    int               cyc;
    logic [AW-1:0]    addr;
    logic [NI-1:0]    mask;
    logic [EW*NI-1:0] data;
  } wexp_t;

  function automatic real f2r(input logic [31:0] x);
    real v;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    v = $itor({9'd1, x[22:0]});
    e = int'(x[30:23]) - 150;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic s;
    int   e;
    real  m;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] fmac(input bit op, input logic [31:0] c, input logic [31:0] a,
                                       input logic [31:0] b);
    real r;
    r = op ? f2r(b) - f2r(c) * f2r(a) : f2r(b) + f2r(c) * f2r(a);
    return r2f(r);
  endfunction

  function automatic logic [EW-1:0] lane(input logic [EW*NI-1:0] v, input int j);
    return v[EW*(NI-j)-1 -: EW];
  endfunction

  function automatic logic [31:0] pick_const();
    case ($urandom_range(0, 3))
      0:       return 32'h40000000;
      1:       return 32'hBFC00000;
      2:       return 32'h3F000000;
      default: return 32'h40400000;
    endcase
  endfunction

  task automatic check(input bit ok, input string nm, input logic [255:0] act,
                       input logic [255:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at t=%0t", nm, act, req, $time);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    localparam int NOE_D = (d == 0) ? 16 : 12;
    localparam int CH    = (NOE_D + NI - 1) / NI;

    logic             busy, done, wr_en, dp_op;
    logic [AW-1:0]    a_rd_addr, b_rd_addr, wr_addr;
    logic [NI-1:0]    wr_mask;
    logic [EW-1:0]    dp_constant;
    logic [EW*NI-1:0] a_rd_data, b_rd_data, dp_first, dp_second, dp_result;
    logic [EW*NI-1:0] pipe [LAT];
`ifdef VXC_SEQ_CYCLE_COUNT_EN
    logic [31:0]      run_cycles;
`endif

    wexp_t wq [$];
    int    dq [$];
    logic  after_rst = 1'b0;
    int    run_lo = 1, run_hi = 0, next_free = 0;

    vxc_row_sequencer #(
      .NOE (NOE_D),
      .NI  (NI),
      .EW  (EW),
      .LAT (LAT),
      .AW  (AW)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op_in       (op_in),
      .constant_in (constant_in),
      .base_addr   (base_addr),
      .busy        (busy),
      .done        (done),
      .a_rd_addr   (a_rd_addr),
      .b_rd_addr   (b_rd_addr),
      .a_rd_data   (a_rd_data),
      .b_rd_data   (b_rd_data),
      .dp_first    (dp_first),
      .dp_second   (dp_second),
      .dp_constant (dp_constant),
      .dp_op       (dp_op),
      .dp_result   (dp_result),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_mask     (wr_mask)
`ifdef VXC_SEQ_CYCLE_COUNT_EN
      ,
      .run_cycles  (run_cycles)
`endif
    );

    always @(posedge clk) begin
      a_rd_data <= mem_a[a_rd_addr];
      b_rd_data <= mem_b[b_rd_addr];
    end

    always @(posedge clk) begin
      for (int j = 0; j < NI; j++)
        pipe[0][EW*(NI-j)-1 -: EW] <= fmac(dp_op, dp_constant, lane(dp_first, j), lane(dp_second, j));
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_result = pipe[LAT-1];

    // Reference: an accepted start at cycle c yields chunk k written at c+2+LAT+k, done one cycle after the last.
    always @(posedge clk) begin
      wexp_t e;
      after_rst <= reset;
      if (reset) begin
        wq.delete();
        dq.delete();
        run_lo    <= 1;
        run_hi    <= 0;
        next_free <= cyc + 1;
      end else if (start && cyc >= next_free) begin
        for (int k = 0; k < CH; k++) begin
          e.cyc  = cyc + 2 + LAT + k;
          e.addr = base_addr + AW'(k);
          e.mask = '0;
          e.data = '0;
          for (int j = 0; j < NI; j++) begin
            if (k * NI + j < NOE_D) begin
              e.mask[j] = 1'b1;
              e.data[EW*(NI-j)-1 -: EW] = fmac(op_in, constant_in, lane(mem_a[e.addr], j),
                                               lane(mem_b[e.addr], j));
            end
          end
          wq.push_back(e);
        end
        dq.push_back(cyc + 3 + LAT + CH - 1);
        run_lo    <= cyc + 1;
        run_hi    <= cyc + 2 + LAT + CH - 1;
        next_free <= cyc + 3 + LAT + CH;
      end
    end

    always @(negedge clk) begin
      wexp_t e;
      if (after_rst) begin
        check({busy, done, wr_en, wr_addr, wr_mask, a_rd_addr, b_rd_addr, dp_op, dp_constant} == '0,
              "reset_ctrl", {busy, done, wr_en, wr_addr, wr_mask, a_rd_addr, b_rd_addr, dp_op, dp_constant}, 0);
        check(dp_first == '0, "reset_dp_first", dp_first, 0);
        check(dp_second == '0, "reset_dp_second", dp_second, 0);
      end
      check(busy == (cyc >= run_lo && cyc <= run_hi), "busy", busy, (cyc >= run_lo && cyc <= run_hi));

      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        check(1'b0, "missing_write", cyc, wq[0].cyc);
        void'(wq.pop_front());
      end
      if (wr_en) begin
        if (wq.size() == 0) begin
          check(1'b0, "unexpected_write", wr_addr, 0);
        end else begin
          e = wq.pop_front();
          check(cyc == e.cyc, "write_cycle", cyc, e.cyc);
          check(wr_addr == e.addr, "wr_addr", wr_addr, e.addr);
          check(wr_mask == e.mask, "wr_mask", wr_mask, e.mask);
          check(dp_result == e.data, "wr_data", dp_result, e.data);
          if (chk_three) check(lane(dp_result, 0) == 32'h40400000, "three", lane(dp_result, 0), 32'h40400000);
        end
      end

      if (dq.size() > 0 && dq[0] < cyc) begin
        check(1'b0, "missing_done", cyc, dq[0]);
        void'(dq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0) begin
          check(1'b0, "unexpected_done", cyc, 0);
        end else begin
          check(cyc == dq[0], "done_cycle", cyc, dq[0]);
`ifdef VXC_SEQ_CYCLE_COUNT_EN
          check(run_cycles == 32'(1 + LAT + CH), "run_cycles", run_cycles, 1 + LAT + CH);
`endif
          void'(dq.pop_front());
        end
      end
    end
  end

  // One start, optional extra start pulses or a reset at given offsets, inputs scrambled after the start.
  task automatic run(input logic [AW-1:0] b, input bit o, input logic [31:0] c,
                     input int p1, input int p2, input int rst_at);
    @(negedge clk);
    start       = 1'b1;
    base_addr   = b;
    op_in       = o;
    constant_in = c;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start       = (i == p1) || (i == p2);
      reset       = (i == rst_at);
      base_addr   = AW'($urandom);
      op_in       = 1'($urandom);
      constant_in = pick_const();
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < NI; j++) begin
        mem_a[a][EW*(NI-j)-1 -: EW] = r2f($itor($urandom_range(0, 128)) - 64.0);
        mem_b[a][EW*(NI-j)-1 -: EW] = r2f($itor($urandom_range(0, 128)) - 64.0);
      end
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run(8'h10, 1'b0, 32'h40000000, 0, 0, 0);

    for (int j = 0; j < NI; j++) begin
      mem_a[8'h20][EW*(NI-j)-1 -: EW] = 32'h3F800000;
      mem_a[8'h21][EW*(NI-j)-1 -: EW] = 32'h3F800000;
      mem_b[8'h20][EW*(NI-j)-1 -: EW] = 32'h40A00000;
      mem_b[8'h21][EW*(NI-j)-1 -: EW] = 32'h40A00000;
    end
    chk_three = 1'b1;
    run(8'h20, 1'b1, 32'h40000000, 0, 0, 0);
    chk_three = 1'b0;

    run(8'hFF, 1'b0, 32'hBFC00000, 0, 0, 0);
    run(8'h30, 1'b1, 32'h3F000000, 1, 4, 0);
    run(8'h40, 1'b0, 32'h40400000, 0, 0, 4);
    run(8'h50, 1'b1, 32'h40000000, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start       = ($urandom_range(0, 3) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      base_addr   = AW'($urandom);
      op_in       = 1'($urandom);
      constant_in = pick_const();
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vxc_row_sequencer.md
# vxc_row_sequencer

Initiator for the NI-lane `result = second ± constant·first` vector datapath in the CG solver. On `start` it streams one NOE-element vector pair, NI elements per chunk, from two row memories into the datapath, one chunk per cycle. It tracks each chunk through the fixed datapath latency and writes the returned result chunks back to a result memory. It pulses `done` after the last write, replacing the datapath's free-running finish counter with exact per-chunk bookkeeping.

## Interface
Parameters:
- NOE, 16, elements per vector
- NI, 8, lanes per chunk
- EW, 32, element width (IEEE-754 single)
- LAT, 4, datapath latency: cycles from operands valid on `dp_*` to `dp_result` valid
- AW, 8, chunk address width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- op_in  in  1  0 = add, 1 = subtract; latched at start
- constant_in  in  EW  scalar multiplier; latched at start
- base_addr  in  AW  chunk base address for all three memories; latched at start
- busy  out  1  high from the cycle after an accepted start until `done`
- done  out  1  one-cycle pulse at run end
- a_rd_addr, b_rd_addr  out  AW  row-memory read addresses; data returns 1 cycle later
- a_rd_data, b_rd_data  in  EW*NI  first-row and second-row chunk data
- dp_first, dp_second  out  EW*NI  datapath operands; lane j at bits [EW*(NI-j)-1 -: EW]
- dp_constant  out  EW  latched constant
- dp_op  out  1  latched op
- dp_result  in  EW*NI  datapath result
- wr_en  out  1  result write strobe
- wr_addr  out  AW  result chunk address
- wr_mask  out  NI  per-lane write enable; bit j maps to lane j

## Operation
- CHUNKS = ceil(NOE/NI). Padding lanes are masked in the last chunk only, and only when NI does not divide NOE. There is no extra chunk when NI divides NOE.
- States:
  - IDLE: `start` → ISSUE, latching op, constant and base.
  - ISSUE: one read per cycle at base+k, k = 0..CHUNKS-1; after the last issue → DRAIN.
  - DRAIN: wait until the in-flight tracker is empty → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- In-flight tracker: a (1+LAT)-deep shift register of {valid, chunk index}, covering read latency plus datapath latency.
- `dp_first` and `dp_second` are the read data passed through. Padding lanes are forced to 0 before reaching the datapath.
- Write: when the tracker tail is valid, assert `wr_en`, set `wr_addr` = base + index, and set `wr_mask` = all ones, or the valid lanes for the last chunk.
- `start` while not in IDLE is ignored. `op_in`, `constant_in` and `base_addr` changes during a run have no effect.
- `reset` at any time (mid-ISSUE or mid-DRAIN) → IDLE, tracker cleared, pending writes dropped. No write occurs in the cycle after reset.
- Address arithmetic wraps modulo 2^AW.

## Timing
- Reset values: busy 0, done 0, wr_en 0, wr_addr 0, wr_mask 0, a/b_rd_addr 0, dp_op 0, dp_constant 0, dp_first/dp_second 0.
- `start` accepted at cycle 0 → first read address at cycle 1 → operands on `dp_*` at cycle 2 → first `wr_en` at cycle 2+LAT.
- Writes are issued on consecutive cycles for chunks 0..CHUNKS-1.
- `done` is asserted at cycle 3+LAT+CHUNKS-1, one cycle after the last write. `busy` drops in the same cycle.
- A new `start` is accepted in the first IDLE cycle after `done`.

## Configuration
- `VXC_SEQ_CYCLE_COUNT_EN` defined: adds output `run_cycles` (32 bits), cleared at start, incremented every busy cycle, and holding the final count after `done` until the next start.
- Undefined: no port and no counter logic. All other behaviour is identical.

## Structure
- Shared package `vxc_pkg`: element width, NI/NOE defaults, the state enum {IDLE, ISSUE, DRAIN, DONE}, a chunk-count function, and a last-chunk lane-mask function.
- One sub-module: `vxc_inflight_tracker`, a parameterised valid/index delay line with synchronous clear.

## Test plan
- NOE=16, NI=8, LAT=4, start with base=0x10 → reads at 0x10 and 0x11. Writes are 2 consecutive cycles at 0x10/0x11 with mask 0xFF, first write at cycle 6, `done` at cycle 8.
- NOE=12, NI=8 → 2 chunks; second write mask 0x0F; `dp_first` lanes 4..7 are 0 on the second chunk.
- op=1, constant=2.0, a=1.0, b=5.0 in every lane, with a behavioural datapath model → every written lane is 3.0 (0x40400000).
- `start` pulsed again mid-ISSUE and mid-DRAIN → ignored: exactly CHUNKS writes and a single `done`.
- `reset` asserted during DRAIN with 2 chunks in flight → no writes afterwards, outputs at reset values, and a later `start` runs normally.
- base=0xFF, AW=8, 2 chunks → writes at 0xFF then 0x00.
